// File: rtl/axi_lite_reg_subsystem.sv
// Command-driven AXI4-Lite master wired to a 16 x 32-bit register-file slave; done pulses 4 cycles after start.
// Backpressure: one transaction per start assertion; slave takes no new request while a B or R response is pending.
module axi_lite_reg_subsystem #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start_write,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        resp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RELEASE
  } state_t;

  state_t state, state_nxt;

  // internal AXI4-Lite bus
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              aw_done, w_done;

  assign awaddr = cmd_addr;
  assign araddr = cmd_addr;
  assign wdata  = cmd_data;
  assign wstrb  = '1;
  assign busy   = (state != IDLE);

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A READY seen while still in the state implies the matching VALID was up.
  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state)
      IDLE: begin
        if (start_write)     state_nxt = WR_ADDR_DATA;
        else if (start_read) state_nxt = RD_ADDR;
      end
      WR_ADDR_DATA: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RELEASE;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!start_write && !start_read) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd_addr <= '0;
      cmd_data <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      rd_data  <= '0;
      resp     <= RESP_OKAY;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (state == IDLE && start_write) begin
        cmd_addr <= addr;
        cmd_data <= data;
      end else if (state == IDLE && start_read) begin
        cmd_addr <= addr;
      end
      if (state == WR_ADDR_DATA) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (bvalid && bready) begin
        resp    <= bresp;
        wr_done <= 1'b1;
      end
      if (rvalid && rready) begin
        resp    <= rresp;
        rd_data <= rdata;
        rd_done <= 1'b1;
      end
    end
  end

  // ---------------- slave ----------------
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              pending;
  logic              wr_hs, rd_hs;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:IDX_W+2] == '0) && (a[1:0] == 2'b00);
  endfunction

  assign pending = bvalid || rvalid;
  assign wr_hs   = awvalid && awready && wvalid && wready;
  assign rd_hs   = arvalid && arready;
  assign wr_idx  = awaddr[IDX_W+1:2];
  assign rd_idx  = araddr[IDX_W+1:2];

  always_ff @(posedge aclk) begin
    if (areset) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // READYs are single-cycle pulses, so a held VALID cannot double-accept
      awready <= awvalid && wvalid && !awready && !pending;
      wready  <= awvalid && wvalid && !awready && !pending;
      arready <= arvalid && !arready && !pending;

      if (wr_hs) begin
        bvalid <= 1'b1;
        if (in_range(awaddr)) begin
          bresp <= RESP_OKAY;
          for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) regs[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end else begin
          bresp <= RESP_SLVERR;
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      if (rd_hs) begin
        rvalid <= 1'b1;
        if (in_range(araddr)) begin
          rdata <= regs[rd_idx];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_subsystem.sv
// Directed bench for axi_lite_reg_subsystem: latency, read-back, priority, range errors and mid-transaction reset.
module tb_axi_lite_reg_subsystem;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start_write, start_read;
  logic [31:0] addr, data;
  logic        busy, wr_done, rd_done;
  logic [31:0] rd_data;
  logic [1:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_lite_reg_subsystem #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
    .aclk(aclk), .areset(areset),
    .start_write(start_write), .start_read(start_read),
    .addr(addr), .data(data),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done),
    .rd_data(rd_data), .resp(resp)
  );

  // Drives one command for `hold` cycles and watches 16 cycles; lat counts from the sampling edge.
  task automatic run_cmd(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input int hold, output int wr_cnt, output int rd_cnt, output int lat,
                         output logic busy1);
    start_write = wr;
    start_read  = rd;
    addr        = a;
    data        = d;
    wr_cnt = 0; rd_cnt = 0; lat = -1; busy1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge aclk); #1;
      if (i == 0) busy1 = busy;
      if (wr_done) wr_cnt++;
      if (rd_done) rd_cnt++;
      if ((wr_done || rd_done) && lat < 0) lat = i + 1;
      if (i == hold - 1) begin
        start_write = 1'b0;
        start_read  = 1'b0;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    areset = 1'b1;
    start_write = 1'b0; start_read = 1'b0;
    repeat (cycles) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    start_write = 1'b0; start_read = 1'b0; addr = '0; data = '0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (wr_done !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_done got %b exp 0", wr_done); end
    n_checks++; if (rd_done !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_done got %b exp 0", rd_done); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    n_checks++; if (resp !== 2'b00)    begin n_fail++; $display("FAIL reset_resp got %b exp 00", resp); end
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic;
    int wc, rc, lat; logic b1;
    run_cmd(1'b1, 1'b0, 32'h08, 32'hDEADBEEF, 2, wc, rc, lat, b1);
    n_checks++; if (wc !== 1)          begin n_fail++; $display("FAIL basic_wr_count got %0d exp 1", wc); end
    n_checks++; if (lat !== 4)         begin n_fail++; $display("FAIL basic_wr_latency got %0d exp 4", lat); end
    n_checks++; if (b1 !== 1'b1)       begin n_fail++; $display("FAIL basic_busy_plus1 got %b exp 1", b1); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    n_checks++; if (resp !== 2'b00)    begin n_fail++; $display("FAIL basic_wr_resp got %b exp 00", resp); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL basic_rd_data_held got %h exp 0", rd_data); end
    run_cmd(1'b0, 1'b1, 32'h08, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rc !== 1 || wc !== 0) begin n_fail++; $display("FAIL basic_rd_count got rd %0d wr %0d exp 1/0", rc, wc); end
    n_checks++; if (lat !== 4)         begin n_fail++; $display("FAIL basic_rd_latency got %0d exp 4", lat); end
    n_checks++; if (rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data got %h exp deadbeef", rd_data); end
    n_checks++; if (resp !== 2'b00)    begin n_fail++; $display("FAIL basic_rd_resp got %b exp 00", resp); end
  endtask

  task automatic test_back_to_back;
    int wc, rc, lat, wtot, rtot; logic b1;
    logic [31:0] a_tab [4];
    logic [31:0] v_tab [4];
    a_tab = '{32'h04, 32'h08, 32'h0C, 32'h10};
    v_tab = '{32'h0A, 32'h11, 32'h10, 32'hC1};
    wtot = 0; rtot = 0;
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b1, 1'b0, a_tab[k], v_tab[k], 5, wc, rc, lat, b1);
      wtot += wc;
      rtot += rc;
    end
    n_checks++; if (wtot !== 4) begin n_fail++; $display("FAIL b2b_wr_pulses got %0d exp 4", wtot); end
    n_checks++; if (rtot !== 0) begin n_fail++; $display("FAIL b2b_rd_pulses got %0d exp 0", rtot); end
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b0, 1'b1, a_tab[k], 32'h0, 5, wc, rc, lat, b1);
      n_checks++;
      if (rd_data !== v_tab[k] || rc !== 1) begin
        n_fail++; $display("FAIL b2b_readback_%0d got %h (rd_done %0d) exp %h", k, rd_data, rc, v_tab[k]);
      end
    end
  endtask

  task automatic test_unwritten;
    int wc, rc, lat; logic b1;
    apply_reset(2);
    run_cmd(1'b0, 1'b1, 32'h2C, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rc !== 1)          begin n_fail++; $display("FAIL unwritten_rd_count got %0d exp 1", rc); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL unwritten_rd_data got %h exp 0", rd_data); end
    n_checks++; if (resp !== 2'b00)    begin n_fail++; $display("FAIL unwritten_resp got %b exp 00", resp); end
    run_cmd(1'b1, 1'b0, 32'h28, 32'h4, 2, wc, rc, lat, b1);
    run_cmd(1'b0, 1'b1, 32'h28, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'h4) begin n_fail++; $display("FAIL unwritten_then_written got %h exp 4", rd_data); end
  endtask

  task automatic test_priority;
    int wc, rc, lat; logic b1;
    run_cmd(1'b1, 1'b1, 32'h1C, 32'h0D, 2, wc, rc, lat, b1);
    n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL prio_wr_count got %0d exp 1", wc); end
    n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL prio_rd_count got %0d exp 0", rc); end
    run_cmd(1'b0, 1'b1, 32'h1C, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'h0D) begin n_fail++; $display("FAIL prio_readback got %h exp 0d", rd_data); end
  endtask

  task automatic test_out_of_range;
    int wc, rc, lat; logic b1;
    run_cmd(1'b1, 1'b0, 32'h10, 32'h77, 2, wc, rc, lat, b1);
    run_cmd(1'b1, 1'b0, 32'h1111, 32'h55, 2, wc, rc, lat, b1);
    n_checks++; if (wc !== 1 || resp !== 2'b10) begin n_fail++; $display("FAIL oor_wr_resp got %b (wr_done %0d) exp 10", resp, wc); end
    run_cmd(1'b0, 1'b1, 32'h10, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'h77) begin n_fail++; $display("FAIL oor_reg_unchanged got %h exp 77", rd_data); end
    n_checks++; if (resp !== 2'b00)     begin n_fail++; $display("FAIL oor_ok_resp got %b exp 00", resp); end
    run_cmd(1'b0, 1'b1, 32'h1111, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rc !== 1 || rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data got %h (rd_done %0d) exp 0", rd_data, rc); end
    n_checks++; if (resp !== 2'b10)     begin n_fail++; $display("FAIL oor_rd_resp got %b exp 10", resp); end
    // just past the top word, and a misaligned address aliasing word 0
    run_cmd(1'b1, 1'b0, 32'h40, 32'h66, 2, wc, rc, lat, b1);
    n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_0x40_resp got %b exp 10", resp); end
    run_cmd(1'b1, 1'b0, 32'h02, 32'h33, 2, wc, rc, lat, b1);
    n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_misaligned_resp got %b exp 10", resp); end
    run_cmd(1'b0, 1'b1, 32'h00, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_word0_unchanged got %h exp 0", rd_data); end
    run_cmd(1'b1, 1'b0, 32'h3C, 32'hAB, 2, wc, rc, lat, b1);
    run_cmd(1'b0, 1'b1, 32'h3C, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'hAB || resp !== 2'b00) begin n_fail++; $display("FAIL top_word got %h resp %b exp ab resp 00", rd_data, resp); end
  endtask

  task automatic test_reset_mid;
    int wc, rc, lat, dones; logic b1;
    run_cmd(1'b1, 1'b0, 32'h04, 32'h99, 2, wc, rc, lat, b1);
    run_cmd(1'b0, 1'b1, 32'h04, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rd_data !== 32'h99) begin n_fail++; $display("FAIL mid_setup_read got %h exp 99", rd_data); end
    run_cmd(1'b1, 1'b0, 32'h1111, 32'h1, 2, wc, rc, lat, b1);
    start_write = 1'b1; addr = 32'h04; data = 32'h1234;
    repeat (3) begin @(posedge aclk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_in_wr_resp got %b exp 1", busy); end
    areset = 1'b1;
    addr   = 32'h1111;
    dones  = 0;
    repeat (3) begin
      @(posedge aclk); #1;
      if (wr_done || rd_done) dones++;
    end
    start_write = 1'b0;
    @(posedge aclk); #1;
    if (wr_done || rd_done) dones++;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rd_data got %h exp 0", rd_data); end
    n_checks++; if (resp !== 2'b00)    begin n_fail++; $display("FAIL mid_reset_resp got %b exp 00", resp); end
    areset = 1'b0;
    repeat (6) begin
      @(posedge aclk); #1;
      if (wr_done || rd_done || busy) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_no_done_or_replay got %0d events exp 0", dones); end
    run_cmd(1'b0, 1'b1, 32'h04, 32'h0, 2, wc, rc, lat, b1);
    n_checks++; if (rc !== 1 || rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_post_reset_read got %h (rd_done %0d) exp 0", rd_data, rc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_unwritten();
    test_priority();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_subsystem.md
# axi_lite_reg_subsystem

Self-contained AXI4-Lite subsystem: a command-driven master connected through an internal AXI4-Lite bus to a slave holding a 16-entry, 32-bit register file. A simple start/addr/data command port on the master launches single write or read transactions. Completion status and read data are returned on the same side. Used as a bus-level building block and as the verification target for AXI4-Lite handshake compliance.

## Interface
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- NUM_REGS, 16, register-file depth (words).
- aclk  in  1  single clock, all logic on rising edge.
- areset  in  1  reset; synchronous, active-high.
- start_write  in  1  level request to launch one write.
- start_read  in  1  level request to launch one read.
- addr  in  ADDR_W  byte address for the command.
- data  in  DATA_W  write data (ignored for reads).
- busy  out  1  master not in IDLE.
- wr_done  out  1  one-cycle pulse at write completion.
- rd_done  out  1  one-cycle pulse at read completion.
- rd_data  out  DATA_W  last read data; held until next read completes.
- resp  out  2  BRESP/RRESP of last completed transaction (00 OKAY, 10 SLVERR).

## Operation
- Internal bus: the AW, W, B, AR and R channels with VALID/READY handshake. A transfer occurs on a cycle where VALID and READY are both high.
- Master FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RELEASE.
- IDLE:
  - start_write=1 → latch addr/data, go to WR_ADDR_DATA.
  - Otherwise start_read=1 → latch addr, go to RD_ADDR.
  - Write has priority when both starts are high; the read is dropped.
- WR_ADDR_DATA: AWVALID=WVALID=1, WSTRB=all ones, AWPROT=ARPROT=0. Each VALID drops independently after its handshake. When both are done → WR_RESP.
- WR_RESP: BREADY=1. On B handshake: capture BRESP into resp, pulse wr_done → RELEASE.
- RD_ADDR: ARVALID=1. On handshake → RD_DATA.
- RD_DATA: RREADY=1. On handshake: capture RDATA into rd_data and RRESP into resp, pulse rd_done → RELEASE.
- RELEASE: wait until start_write=0 and start_read=0 → IDLE. One transaction per start assertion regardless of how long start is held.
- Slave decode:
  - Word index = addr[5:2].
  - addr[ADDR_W-1:6] must be 0 and addr[1:0] must be 0; otherwise the access is out of range.
- Slave write: completes the AW and W handshakes, applies WSTRB byte enables, responds OKAY.
- Out-of-range write: register file unchanged, BRESP=SLVERR.
- Slave read: RDATA = register contents, RRESP=OKAY.
- Out-of-range read: RDATA=0, RRESP=SLVERR.
- Slave accepts a new AW/W or AR only when no B or R response is pending.

## Timing
- Reset (areset=1 at a clock edge):
  - Master → IDLE; all master VALID/READY outputs 0.
  - busy=0, wr_done=0, rd_done=0, rd_data=0, resp=00.
  - All registers = 0; slave READY/BVALID/RVALID = 0.
  - Commands presented during reset are ignored and not remembered.
- Slave AWREADY/WREADY are registered: both pulse high for one cycle, the cycle after AWVALID and WVALID are both seen high. BVALID rises the next cycle and holds until BREADY.
- ARREADY pulses one cycle after ARVALID is seen. RVALID rises the next cycle with RDATA and holds until RREADY.
- VALID signals never drop before their handshake. Payload is stable while VALID is high.
- Latency from the cycle start is sampled in IDLE:
  - Write: AWVALID/WVALID at +1, handshake at +2, BVALID at +3, wr_done at +4.
  - Read: ARVALID at +1, handshake at +2, RVALID at +3, rd_done and rd_data valid at +4.
- busy is high from +1 through the RELEASE exit.
- A register write is visible to a read launched in any later transaction.
- Reset asserted mid-transaction aborts it. No done pulse; register contents are cleared.

## Test plan
- Reset, write 0xDEADBEEF to 0x08, then read 0x08 → wr_done at +4; rd_data=0xDEADBEEF, resp=OKAY.
- Consecutive writes 0x04←0x0A, 0x08←0x11, 0x0C←0x10, 0x10←0xC1, each start held 5 cycles → exactly 4 wr_done pulses. Read-back returns 0x0A, 0x11, 0x10, 0xC1.
- Read never-written 0x2C after reset → rd_data=0, resp=OKAY. Then write 0x28←0x4 and read 0x28 → 0x4.
- start_write and start_read both high, addr 0x1C, data 0x0D → one write, no rd_done. A later read of 0x1C returns 0x0D.
- Out-of-range: write addr 0x1111 data 0x55 → resp=SLVERR, register file unchanged. Read 0x1111 → rd_data=0, resp=SLVERR.
- Assert areset during WR_RESP of a write to 0x04, and issue start_write with addr 0x1111 while reset is held → no done pulse, all outputs at reset values. Post-reset read of 0x04 returns 0.
